passageway_chain_monitor: RTL and testbench
===========================================

Name: passageway_chain_monitor

Overview:
- Observer for an N-zone passageway SUT. Each step the tester drives iup/iright; the SUT reports its next-state properties on controllable_* inputs.
- The block tracks the zone and door mode, and latches a sticky error with a cause code on any rule violation.
- It counts steps and faults, and raises objective when the target zone is reached fault-free within a deadline.
- Successor to the fixed 3-zone corridor monitor: adds parametrised zone chain, fault threshold, deadline, one-hot checking and error diagnostics.

Parameters:
- NZONES, 4, number of zones in the chain (>=2); zone 0 is the start, zones are linked k <-> k+1 by doors
- TARGET, NZONES-1, zone index that satisfies the objective
- MAX_FAULTS, 1, number of controllable_fault pulses that latch the fault flag (>=1)
- DEADLINE, 32, last step index at which objective may assert (steps counted after the init cycle)
- STRICT_ONEHOT, 1, 1 = controllable_zone not exactly one-hot is an error; 0 = ignore and hold zone
- ZW, $clog2(NZONES), zone index width (derived, not overridden)
- SW, $clog2(DEADLINE+2), step counter width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- iup  in  1  tester move: 1 = up, 0 = down
- iright  in  1  tester move: 1 = right, 0 = left
- controllable_zone  in  NZONES  one-hot zone reported by SUT
- controllable_open  in  1  door open
- controllable_doorstep  in  1  SUT at doorstep
- controllable_fault  in  1  SUT fault pulse
- error  out  1  sticky violation flag
- err_cause  out  3  cause of first violation (0 = none)
- objective  out  1  target reached, no fault, no error, within deadline
- zone  out  ZW  tracked zone index
- steps  out  SW  saturating step count

Behaviour:
- Reset (rst=1 at posedge): notfirst=0, zone=0, mode=CLOSED, error=0, err_cause=0, fault=0, fault count=0, steps=0. All outputs read 0 the following cycle. rst mid-run discards all state in one cycle.
- Init cycle: first posedge with notfirst=0 only sets notfirst=1; inputs are ignored.
- Each later posedge is one step. All updates use the current (pre-edge) zone and mode.
- Step/fault counters:
  - steps += 1, saturating at 2^SW-1.
  - fault count += controllable_fault, saturating at MAX_FAULTS; fault = (count == MAX_FAULTS), sticky.
- Mode next: ~open -> CLOSED; open & ~doorstep -> OPEN; open & doorstep -> DOORSTEP.
- Zone next, with r = index of lowest set bit of controllable_zone:
  - r==0 -> 0.
  - Else r==zone+1 and mode==DOORSTEP -> r.
  - Else r==zone-1 -> r.
  - Else hold.
  - A one-hot violation always holds the zone.
- Error rules, evaluated on current mode; first match by priority sets err_cause:
  - 1 ONEHOT: STRICT_ONEHOT and controllable_zone is not exactly one-hot.
  - 2 CLOSED: mode CLOSED and iup & controllable_open.
  - 3 OPEN: mode OPEN and ~iright & doorstep & controllable_zone[zone].
  - 4 STEP: mode DOORSTEP, zone<NZONES-1, and (iright & ~controllable_zone[zone+1] or ~iright & controllable_zone[zone+1]).
  - 5 LAST: mode DOORSTEP, zone==NZONES-1, and iright (no door beyond last zone).
- error/err_cause are sticky: once error=1, err_cause is frozen until rst. Zone, mode and counters keep updating after an error.
- objective = notfirst & ~fault & ~error & (zone==TARGET) & (steps<=DEADLINE). Combinational from registers, no extra latency.
- Simultaneous events: when fault and error both set in the same step, both are latched. Objective drops the cycle after either is set.

Decomposition:
- passageway_pkg:
  - mode_t enum (CLOSED=0, OPEN=1, DOORSTEP=2), 2 bits
  - err_cause_t codes 0..5
  - function onehot_ok
  - function lowest_index
- Sub-module sat_counter #(W, MAX): used for steps and fault count; inc input, synchronous rst.

Test Plan:
- rst=1 for 2 cycles, then 1 init cycle with controllable_fault=1 -> fault=0, error=0, zone=0, steps=0 after the init edge.
- NZONES=4: per step, open+doorstep, then iright with zone bit k+1, for k=0..2 -> zone walks 0,1,2,3; objective=1 at steps=6 (<=32); error=0.
- Mode CLOSED, iup=1, controllable_open=1 -> error=1, err_cause=2 next cycle; zone keeps tracking later moves; err_cause stays 2.
- controllable_zone=4'b0110 with STRICT_ONEHOT=1 -> err_cause=1, zone held; same stimulus with STRICT_ONEHOT=0 -> error stays 0, zone held.
- MAX_FAULTS=2: one fault pulse -> objective still 1 at target; second pulse -> fault=1, objective=0 next cycle.
- DEADLINE=4: reach target at step 6 -> objective=0; rst mid-walk at step 3 -> zone=0, steps=0 next cycle.

Source files
------------

// File: rtl/passageway_pkg.sv
`default_nettype none
// ============================================================================
// Module      : passageway_pkg
// Description : Shared types and helpers for the passageway chain monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package passageway_pkg;

    localparam int c_MAX_ZONES = 64;
    localparam int c_IDX_W     = $clog2(c_MAX_ZONES);

    typedef enum logic [1:0] {
        MODE_CLOSED   = 2'd0,
        MODE_OPEN     = 2'd1,
        MODE_DOORSTEP = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_ONEHOT = 3'd1,
        ERR_CLOSED = 3'd2,
        ERR_OPEN   = 3'd3,
        ERR_STEP   = 3'd4,
        ERR_LAST   = 3'd5
    } err_cause_t;

    // Callers zero-extend their zone vector to c_MAX_ZONES bits.
    function automatic logic onehot_ok(input logic [c_MAX_ZONES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_MAX_ZONES; i++) begin
            n += 32'(v[i]);
        end
        return (n == 1);
    endfunction

    function automatic logic [c_IDX_W-1:0] lowest_index(input logic [c_MAX_ZONES-1:0] v);
        logic [c_IDX_W-1:0] idx;
        idx = '0;
        for (int i = c_MAX_ZONES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = c_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that stops at MAX; synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != W'(MAX))) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/passageway_chain_monitor.sv
`default_nettype none
// ============================================================================
// Module      : passageway_chain_monitor
// Description : Tracks zone/door mode of an N-zone passageway SUT, latches
//               the first rule violation and flags the reach objective.
// Revision    : 1.0 - initial release
// ============================================================================
module passageway_chain_monitor
    import passageway_pkg::*;
#(
    parameter  int NZONES        = 4,
    parameter  int TARGET        = NZONES - 1,
    parameter  int MAX_FAULTS    = 1,
    parameter  int DEADLINE      = 32,
    parameter  int STRICT_ONEHOT = 1,
    localparam int ZW            = $clog2(NZONES),
    localparam int SW            = $clog2(DEADLINE + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iup,
    input  logic              iright,
    input  logic [NZONES-1:0] controllable_zone,
    input  logic              controllable_open,
    input  logic              controllable_doorstep,
    input  logic              controllable_fault,
    output logic              error,
    output logic [2:0]        err_cause,
    output logic              objective,
    output logic [ZW-1:0]     zone,
    output logic [SW-1:0]     steps
);

    localparam int c_FW = $clog2(MAX_FAULTS + 1);

    logic                   r_notfirst;
    mode_t                  r_mode;
    mode_t                  w_mode_next;
    logic [ZW-1:0]          r_zone;
    logic [ZW-1:0]          w_zone_next;
    logic                   r_error;
    err_cause_t             r_cause;
    err_cause_t             w_cause;
    logic [c_MAX_ZONES-1:0] w_zone_ext;
    logic                   w_onehot;
    logic [c_IDX_W-1:0]     w_low;
    logic                   w_cur_bit;
    logic                   w_nxt_bit;
    logic                   w_at_last;
    logic [c_FW-1:0]        w_fault_cnt;
    logic                   w_fault;
    logic [SW-1:0]          w_steps;

    assign w_zone_ext = c_MAX_ZONES'(controllable_zone);
    assign w_onehot   = onehot_ok(w_zone_ext);
    assign w_low      = lowest_index(w_zone_ext);
    assign w_cur_bit  = |(controllable_zone & (NZONES'(1) << r_zone));
    assign w_nxt_bit  = |(controllable_zone & (NZONES'(2) << r_zone));
    assign w_at_last  = (r_zone == ZW'(NZONES - 1));

    sat_counter #(.W(SW), .MAX((2 ** SW) - 1)) u_step_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (r_notfirst),
        .o_count (w_steps)
    );

    sat_counter #(.W(c_FW), .MAX(MAX_FAULTS)) u_fault_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (r_notfirst & controllable_fault),
        .o_count (w_fault_cnt)
    );

    assign w_fault = (w_fault_cnt == c_FW'(MAX_FAULTS));

    always_comb begin
        w_mode_next = MODE_CLOSED;
        w_zone_next = r_zone;
        w_cause     = ERR_NONE;

        if (controllable_open) begin
            w_mode_next = controllable_doorstep ? MODE_DOORSTEP : MODE_OPEN;
        end

        // A malformed zone report never moves the tracked zone.
        if (w_onehot) begin
            if (w_low == '0) begin
                w_zone_next = '0;
            end else if ((int'(w_low) == int'(r_zone) + 1) && (r_mode == MODE_DOORSTEP)) begin
                w_zone_next = ZW'(w_low);
            end else if (int'(w_low) == int'(r_zone) - 1) begin
                w_zone_next = ZW'(w_low);
            end
        end

        if ((STRICT_ONEHOT != 0) && !w_onehot) begin
            w_cause = ERR_ONEHOT;
        end else if ((r_mode == MODE_CLOSED) && iup && controllable_open) begin
            w_cause = ERR_CLOSED;
        end else if ((r_mode == MODE_OPEN) && !iright && controllable_doorstep && w_cur_bit) begin
            w_cause = ERR_OPEN;
        end else if ((r_mode == MODE_DOORSTEP) && !w_at_last && (iright != w_nxt_bit)) begin
            w_cause = ERR_STEP;
        end else if ((r_mode == MODE_DOORSTEP) && w_at_last && iright) begin
            w_cause = ERR_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_notfirst <= 1'b0;
            r_mode     <= MODE_CLOSED;
            r_zone     <= '0;
            r_error    <= 1'b0;
            r_cause    <= ERR_NONE;
        end else if (!r_notfirst) begin
            r_notfirst <= 1'b1;
        end else begin
            r_mode <= w_mode_next;
            r_zone <= w_zone_next;
            if (!r_error && (w_cause != ERR_NONE)) begin
                r_error <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign error     = r_error;
    assign err_cause = r_cause;
    assign zone      = r_zone;
    assign steps     = w_steps;
    assign objective = r_notfirst & ~w_fault & ~r_error
                     & (r_zone == ZW'(TARGET))
                     & (32'(w_steps) <= 32'(DEADLINE));

endmodule
`default_nettype wire

// File: tb/tb_passageway_chain_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_passageway_chain_monitor
// Description : Directed self-checking bench driving four parameter variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_passageway_chain_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       iup;
    logic       iright;
    logic [3:0] cz;
    logic       copen;
    logic       cdoor;
    logic       cfault;

    logic       d_err, l_err, m_err, t_err;
    logic [2:0] d_cause, l_cause, m_cause, t_cause;
    logic       d_obj, l_obj, m_obj, t_obj;
    logic [1:0] d_zone, l_zone, m_zone, t_zone;
    logic [5:0] d_steps, l_steps, m_steps;
    logic [2:0] t_steps;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    passageway_chain_monitor u_dut (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright),
        .controllable_zone(cz), .controllable_open(copen),
        .controllable_doorstep(cdoor), .controllable_fault(cfault),
        .error(d_err), .err_cause(d_cause), .objective(d_obj),
        .zone(d_zone), .steps(d_steps)
    );

    passageway_chain_monitor #(.STRICT_ONEHOT(0)) u_lax (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright),
        .controllable_zone(cz), .controllable_open(copen),
        .controllable_doorstep(cdoor), .controllable_fault(cfault),
        .error(l_err), .err_cause(l_cause), .objective(l_obj),
        .zone(l_zone), .steps(l_steps)
    );

    passageway_chain_monitor #(.MAX_FAULTS(2)) u_mf2 (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright),
        .controllable_zone(cz), .controllable_open(copen),
        .controllable_doorstep(cdoor), .controllable_fault(cfault),
        .error(m_err), .err_cause(m_cause), .objective(m_obj),
        .zone(m_zone), .steps(m_steps)
    );

    passageway_chain_monitor #(.DEADLINE(4)) u_dl4 (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright),
        .controllable_zone(cz), .controllable_open(copen),
        .controllable_doorstep(cdoor), .controllable_fault(cfault),
        .error(t_err), .err_cause(t_cause), .objective(t_obj),
        .zone(t_zone), .steps(t_steps)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic up, input logic rt, input logic [3:0] z,
                         input logic op, input logic ds, input logic ft);
        iup    = up;
        iright = rt;
        cz     = z;
        copen  = op;
        cdoor  = ds;
        cfault = ft;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        iup = 1'b0; iright = 1'b0; cz = 4'b0001;
        copen = 1'b0; cdoor = 1'b0; cfault = 1'b0;
        tick();
        tick();
        chk("rst_error",     32'(d_err),   0);
        chk("rst_cause",     32'(d_cause), 0);
        chk("rst_objective", 32'(d_obj),   0);
        chk("rst_zone",      32'(d_zone),  0);
        chk("rst_steps",     32'(d_steps), 0);

        // Init cycle ignores the fault pulse.
        rst = 1'b0;
        drive(0, 0, 4'b0001, 0, 0, 1);
        chk("init_error", 32'(d_err),   0);
        chk("init_zone",  32'(d_zone),  0);
        chk("init_steps", 32'(d_steps), 0);

        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 4'(1 << k), 1, 1, 0);
            drive(0, 1, 4'(1 << (k + 1)), 1, 1, 0);
            chk("walk_zone", 32'(d_zone), 32'(k + 1));
        end
        chk("walk_steps",     32'(d_steps), 6);
        chk("walk_objective", 32'(d_obj),   1);
        chk("walk_error",     32'(d_err),   0);
        chk("lax_objective",  32'(l_obj),   1);
        chk("mf2_objective",  32'(m_obj),   1);
        chk("dl4_zone",       32'(t_zone),  3);
        chk("dl4_steps",      32'(t_steps), 6);
        chk("dl4_objective",  32'(t_obj),   0);

        drive(0, 0, 4'b1000, 1, 1, 1);
        chk("fault1_dut_obj", 32'(d_obj),  0);
        chk("fault1_dut_err", 32'(d_err),  0);
        chk("fault1_mf2_obj", 32'(m_obj),  1);
        chk("fault1_zone",    32'(d_zone), 3);
        drive(0, 0, 4'b1000, 1, 1, 1);
        chk("fault2_mf2_obj", 32'(m_obj),  0);
        chk("fault2_steps",   32'(d_steps), 8);

        drive(0, 1, 4'b1000, 1, 1, 0);
        chk("last_error", 32'(d_err),   1);
        chk("last_cause", 32'(d_cause), 5);

        // Reset in the middle of a walk.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 4'b0001, 0, 0, 0);
        drive(0, 0, 4'b0001, 1, 1, 0);
        drive(0, 1, 4'b0010, 1, 1, 0);
        drive(0, 0, 4'b0010, 1, 1, 0);
        chk("mid_steps", 32'(t_steps), 3);
        chk("mid_zone",  32'(t_zone),  1);
        rst = 1'b1;
        tick();
        chk("midrst_zone",  32'(t_zone),  0);
        chk("midrst_steps", 32'(t_steps), 0);
        chk("midrst_error", 32'(d_err),   0);
        chk("midrst_cause", 32'(d_cause), 0);

        rst = 1'b0;
        drive(0, 0, 4'b0001, 0, 0, 0);
        drive(1, 0, 4'b0001, 1, 0, 0);
        chk("closed_error",     32'(d_err),   1);
        chk("closed_cause",     32'(d_cause), 2);
        chk("closed_lax_cause", 32'(l_cause), 2);
        drive(0, 0, 4'b0001, 1, 1, 0);
        drive(0, 1, 4'b0010, 1, 1, 0);
        chk("closed_track_zone", 32'(d_zone),  1);
        chk("closed_frozen",     32'(d_cause), 2);
        chk("closed_objective",  32'(d_obj),   0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 4'b0001, 0, 0, 0);
        drive(0, 0, 4'b0001, 1, 1, 0);
        drive(0, 1, 4'b0010, 1, 1, 0);
        drive(0, 1, 4'b1100, 1, 1, 0);
        chk("onehot_cause",     32'(d_cause), 1);
        chk("onehot_zone",      32'(d_zone),  1);
        chk("onehot_lax_error", 32'(l_err),   0);
        chk("onehot_lax_zone",  32'(l_zone),  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
